bpd_upd_sched: RTL
==================

# bpd_upd_sched

Retire-side update scheduler for the tournament branch predictor tables (choice PHT, global PHT, local BHT, local PHT). It buffers branch-resolution updates from the retire stage in a small FIFO and replays them one per cycle onto the shared predictor write port, holding each write while the table arrays stall it. It also runs a table-clear sweep on request, for context switch or predictor flush, that rewrites every entry with its init value. It sits between retire/BOB and the predictor tables; the speculative read path is untouched.

## Interface
- DEPTH, 4, update FIFO entries (power of 2, ≥2)
- CLR_ENTRIES, 4096, entries swept by a clear (largest table)
- LOG_CLR, 12, width of clear counter
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- upd_vld_i  in  1  retire branch update valid
- upd_pc_i  in  64  branch PC
- upd_bhr_i  in  12  global history at prediction
- upd_lochist_i  in  10  local history at prediction
- upd_brdir_i  in  1  resolved direction
- upd_ch_we_i  in  1  choice-table update enable (global≠local)
- upd_ch_brdir_i  in  1  local prediction used for choice update
- upd_rdy_o  out  1  update accepted this cycle if high
- clr_req_i  in  1  request table clear (single-cycle pulse)
- clr_busy_o  out  1  drain or clear in progress
- tbl_stall_i  in  1  table write port busy; hold current write
- tbl_we_o  out  1  write valid
- tbl_init_o  out  1  write is a clear (tables load SATCNT_INIT / zero history)
- tbl_ch_idx_o  out  12  choice PHT index
- tbl_gl_idx_o  out  12  global PHT index
- tbl_bht_idx_o  out  10  BHT index
- tbl_lo_idx_o  out  10  local PHT index
- tbl_brdir_o  out  1  direction for global/local PHT and BHT shift-in
- tbl_ch_we_o  out  1  choice PHT write enable
- tbl_ch_brdir_o  out  1  choice direction = brdir ^ ch_brdir (1 = favour global)

## Operation
- Reset: FIFO empty, state IDLE, clear counter 0; all tbl_* outputs 0, clr_busy_o 0, upd_rdy_o 1.
- upd_rdy_o = (state==IDLE) & !full. Push on upd_vld_i & upd_rdy_o. upd_vld_i while upd_rdy_o low is dropped with no state change.
- Push while full is never allowed, even with a same-cycle pop. Push while empty plus pop of the same entry cannot occur, since FIFO output is registered.
- Write payload from FIFO head: ch_idx = pc[13:2]; gl_idx = pc[13:2]^bhr; bht_idx = pc[11:2]; lo_idx = lochist; brdir; ch_we; ch_brdir = brdir^upd_ch_brdir. tbl_we_o = !empty, tbl_init_o = 0.
- Pop when tbl_we_o & !tbl_stall_i. While stalled, payload is held bit-stable.
- FSM:
  - IDLE: on clr_req_i, go to DRAIN. An update pushed in the same cycle is still accepted.
  - DRAIN: no pushes; FIFO keeps writing. When FIFO is empty, go to CLEAR with counter 0.
  - CLEAR: tbl_we_o = 1, tbl_init_o = 1, ch_idx = gl_idx = cnt[11:0], bht_idx = lo_idx = cnt[9:0], tbl_ch_we_o = 1, brdir and ch_brdir = 0. Counter increments on each unstalled cycle. The unstalled write at cnt = CLR_ENTRIES-1 returns the FSM to IDLE and resets the counter to 0.
- clr_busy_o = (state != IDLE).
- clr_req_i in DRAIN or CLEAR is ignored; no re-arm or queuing.
- Asynchronous reset mid-clear or mid-drain: abandons the operation and discards FIFO contents.

## Timing
- Update pushed at edge N appears on tbl_we_o in cycle N+1 when the FIFO was empty, or behind earlier entries otherwise.
- Throughput: 1 write per unstalled cycle.
- Full: DEPTH unretired entries. upd_rdy_o falls combinationally in the cycle the FIFO is full and rises in the cycle after a pop.
- clr_req_i at edge N with an empty FIFO:
  - DRAIN at N+1, CLEAR at N+2 (a DRAIN cycle always occurs).
  - Clear writes occupy CLR_ENTRIES unstalled cycles.
  - clr_busy_o is low, and upd_rdy_o high, the cycle after the final clear write.
- Stall cycles extend drain and clear one for one; no write is skipped or duplicated.

## Test plan
- Reset → upd_rdy_o=1, tbl_we_o=0, clr_busy_o=0.
- Single update:
  - Stimulus: pc=0x1000, bhr=0xFFF, lochist=0x155, brdir=1, ch_we=1, ch_brdir=0, no stall.
  - Response: next cycle tbl_we_o=1, ch_idx=0x400, gl_idx=0xBFF, bht_idx=0x000, lo_idx=0x155, tbl_ch_brdir_o=1. FIFO empty the cycle after.
- Full/back-pressure: tbl_stall_i=1, push 5 updates → first 4 accepted, upd_rdy_o=0 on the 5th (dropped). Release stall → 4 writes in order, payload stable across the stall.
- Clear with pending updates:
  - Stimulus: 2 queued updates plus clr_req_i.
  - Response: both updates written first, then 4096 init writes with idx 0..4095, then clr_busy_o drops. upd_vld_i during the clear is dropped.
- Stalled clear: tbl_stall_i toggling every other cycle → exactly 4096 distinct indices written, total 8192±1 cycles; second clr_req_i mid-clear is ignored.
- Reset asserted at cnt=100 → outputs 0 immediately, state IDLE and FIFO empty after release.

Source files
------------

// File: rtl/bpd_upd_sched.sv
// Retire-side update scheduler for the tournament predictor tables: queues branch
// updates, replays one per cycle onto the shared table write port, and runs clear sweeps.
module bpd_upd_sched #(
  parameter int DEPTH       = 4,
  parameter int CLR_ENTRIES = 4096,
  parameter int LOG_CLR     = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        upd_vld_i,
  input  logic [63:0] upd_pc_i,
  input  logic [11:0] upd_bhr_i,
  input  logic [9:0]  upd_lochist_i,
  input  logic        upd_brdir_i,
  input  logic        upd_ch_we_i,
  input  logic        upd_ch_brdir_i,
  output logic        upd_rdy_o,
  input  logic        clr_req_i,
  output logic        clr_busy_o,
  input  logic        tbl_stall_i,
  output logic        tbl_we_o,
  output logic        tbl_init_o,
  output logic [11:0] tbl_ch_idx_o,
  output logic [11:0] tbl_gl_idx_o,
  output logic [9:0]  tbl_bht_idx_o,
  output logic [9:0]  tbl_lo_idx_o,
  output logic        tbl_brdir_o,
  output logic        tbl_ch_we_o,
  output logic        tbl_ch_brdir_o
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  // only the PC bits the tables index with are kept; choice direction is pre-xored
  typedef struct packed {
    logic [11:0] pc_idx;
    logic [11:0] bhr;
    logic [9:0]  lochist;
    logic        brdir;
    logic        ch_we;
    logic        ch_brdir;
  } upd_t;

  upd_t               mem [DEPTH];
  upd_t               head;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        fifo_cnt;
  logic [LOG_CLR-1:0] clr_cnt;
  state_t             state_q, state_d;
  logic               empty, full, push, pop, clr_last;

  assign empty     = (fifo_cnt == '0);
  assign full      = (fifo_cnt == (PW+1)'(DEPTH));
  assign upd_rdy_o = (state_q == IDLE) && !full;
  assign push      = upd_vld_i && upd_rdy_o;
  assign pop       = !empty && !tbl_stall_i;
  assign head      = mem[rd_ptr];
  assign clr_last  = (clr_cnt == LOG_CLR'(CLR_ENTRIES-1));
  assign clr_busy_o = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= '{pc_idx: upd_pc_i[13:2], bhr: upd_bhr_i, lochist: upd_lochist_i,
                       brdir: upd_brdir_i, ch_we: upd_ch_we_i,
                       ch_brdir: upd_brdir_i ^ upd_ch_brdir_i};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req_i) state_d = DRAIN;
      DRAIN:   if (empty) state_d = CLEAR;
      CLEAR:   if (!tbl_stall_i && clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) clr_cnt <= '0;
    else if (state_q == CLEAR && !tbl_stall_i)
      clr_cnt <= clr_last ? '0 : clr_cnt + LOG_CLR'(1);
  end

  // payload is forced to zero when no write is presented
  always_comb begin
    tbl_we_o       = 1'b0;
    tbl_init_o     = 1'b0;
    tbl_ch_idx_o   = '0;
    tbl_gl_idx_o   = '0;
    tbl_bht_idx_o  = '0;
    tbl_lo_idx_o   = '0;
    tbl_brdir_o    = 1'b0;
    tbl_ch_we_o    = 1'b0;
    tbl_ch_brdir_o = 1'b0;
    if (state_q == CLEAR) begin
      tbl_we_o      = 1'b1;
      tbl_init_o    = 1'b1;
      tbl_ch_idx_o  = clr_cnt[11:0];
      tbl_gl_idx_o  = clr_cnt[11:0];
      tbl_bht_idx_o = clr_cnt[9:0];
      tbl_lo_idx_o  = clr_cnt[9:0];
      tbl_ch_we_o   = 1'b1;
    end else if (!empty) begin
      tbl_we_o       = 1'b1;
      tbl_ch_idx_o   = head.pc_idx;
      tbl_gl_idx_o   = head.pc_idx ^ head.bhr;
      tbl_bht_idx_o  = head.pc_idx[9:0];
      tbl_lo_idx_o   = head.lochist;
      tbl_brdir_o    = head.brdir;
      tbl_ch_we_o    = head.ch_we;
      tbl_ch_brdir_o = head.ch_brdir;
    end
  end
endmodule
